// File: rtl/i2s_rx_pkg.sv
// Shared constants for the I2S receive path: channel codes, synchroniser depth
// and the frame-alignment state encodings (also used by the transmit side).
package i2s_rx_pkg;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_WAIT_L = 2'd1;
    localparam logic [1:0] ST_HAVE_L = 2'd2;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Synchroniser for an asynchronous clock-like input followed by one extra
// flop, so a rising edge can be detected cleanly in the clk domain.
module sync_edge
    import i2s_rx_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES:0] sync_sh;

    // Shift the raw input through the synchroniser plus the edge-detect flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_sh <= '0;
        end else begin
            sync_sh <= {sync_sh[SYNC_STAGES-1:0], din};
        end
    end

    assign rise = sync_sh[SYNC_STAGES-1] & ~sync_sh[SYNC_STAGES];

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S slave receiver. SCLK/LRCLK/SDATA are oversampled in the clk
// domain; each LRCLK change marks the LSB slot of the current word (1-bit
// I2S delay). Left and right words are paired and presented together with a
// one-cycle strobe once the receiver has aligned to a frame boundary.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i2s_sclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             sample_stb,
    output logic             locked,
    output logic             short_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    // Left-justify a word that may have arrived with fewer than WIDTH bits
    function automatic logic [WIDTH-1:0] msb_align(input logic [WIDTH-1:0] w,
                                                   input logic [CNT_W-1:0] n);
        msb_align = w << (WIDTH - int'(n));
    endfunction

    logic                   sclk_rise;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   lr_s2;
    logic                   sd_s2;

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic             chan;
    logic [1:0]       state;
    logic [TO_W-1:0]  to_cnt;
    logic [WIDTH-1:0] left_hold;

    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] word;
    logic             short_word;
    logic             word_end;
    logic             timeout;

    sync_edge u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (i2s_sclk),
        .rise    (sclk_rise)
    );

    // Word select and data follow the same depth as SCLK so they line up with the edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_sync <= '0;
            sd_sync <= '0;
        end else begin
            lr_sync <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
        end
    end

    assign lr_s2 = lr_sync[SYNC_STAGES-1];
    assign sd_s2 = sd_sync[SYNC_STAGES-1];

    // Next shift state including the bit on this edge; surplus bits are dropped
    always_comb begin
        shreg_nxt = shreg;
        cnt_nxt   = bitcnt;
        if (bitcnt < CNT_FULL) begin
            shreg_nxt = {shreg[WIDTH-2:0], sd_s2};
            cnt_nxt   = bitcnt + 1'b1;
        end
        word       = msb_align(shreg_nxt, cnt_nxt);
        short_word = (cnt_nxt < CNT_FULL);
        word_end   = sclk_rise && (lr_s2 != chan);
        timeout    = (to_cnt == TO_MAX);
    end

    // Deserialiser, frame alignment, SCLK watchdog and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            bitcnt     <= '0;
            chan       <= CH_LEFT;
            state      <= ST_UNSYNC;
            to_cnt     <= '0;
            left_hold  <= '0;
            left_chan  <= '0;
            right_chan <= '0;
            sample_stb <= 1'b0;
            locked     <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            short_err  <= 1'b0;

            if (sclk_rise) begin
                to_cnt <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // A stalled bit clock overrides any word completing in the same cycle
            if (timeout) begin
                locked <= 1'b0;
                state  <= ST_UNSYNC;
                shreg  <= '0;
                bitcnt <= '0;
            end else if (sclk_rise) begin
                if (word_end) begin
                    shreg  <= '0;
                    bitcnt <= '0;
                    chan   <= lr_s2;
                    if (state != ST_UNSYNC) begin
                        short_err <= short_word;
                    end
                    case (state)
                        ST_UNSYNC: state <= ST_WAIT_L;
                        ST_WAIT_L: begin
                            if (chan == CH_LEFT) begin
                                left_hold <= word;
                                state     <= ST_HAVE_L;
                            end
                        end
                        ST_HAVE_L: begin
                            if (chan == CH_RIGHT) begin
                                left_chan  <= left_hold;
                                right_chan <= word;
                                sample_stb <= 1'b1;
                                locked     <= 1'b1;
                                state      <= ST_WAIT_L;
                            end else begin
                                left_hold <= word;
                            end
                        end
                        default: state <= ST_UNSYNC;
                    endcase
                end else begin
                    shreg  <= shreg_nxt;
                    bitcnt <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives Philips-format frames with SCLK = clk/8
// and checks paired outputs, lock behaviour, short words, resets and timeout.
module tb_i2s_rx;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 4096;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i2s_sclk = 1'b0;
    logic             i2s_lrclk = 1'b0;
    logic             i2s_sdata = 1'b0;
    logic [WIDTH-1:0] left_chan;
    logic [WIDTH-1:0] right_chan;
    logic             sample_stb;
    logic             locked;
    logic             short_err;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_count   = 0;
    int short_count = 0;

    i2s_rx #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i2s_sclk   (i2s_sclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .sample_stb (sample_stb),
        .locked     (locked),
        .short_err  (short_err)
    );

    always #5 clk = ~clk;

    // Count strobes and short-word pulses away from the active edge
    always @(negedge clk) begin
        if (sample_stb) stb_count <= stb_count + 1;
        if (short_err) short_count <= short_count + 1;
    end

    // One SCLK period: LRCLK/SDATA change with the falling edge, sampled on the rise
    task automatic send_bit(input logic lr, input logic d);
        i2s_sclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = d;
        #40;
        i2s_sclk = 1'b1;
        #40;
    endtask

    // Bits hi..lo of a word on channel ch; the LSB slot already shows the next channel
    task automatic send_bits(input logic ch, input logic [31:0] data, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            send_bit((i == 0) ? ~ch : ch, data[i]);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_bits(1'b0, l, n - 1, 0);
        send_bits(1'b1, r, n - 1, 0);
    endtask

    task automatic test_reset;
        n_checks++; if (left_chan !== 16'h0) begin n_fail++; $display("FAIL reset_left: got %h expected 0000", left_chan); end
        n_checks++; if (right_chan !== 16'h0) begin n_fail++; $display("FAIL reset_right: got %h expected 0000", right_chan); end
        n_checks++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0", sample_stb); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_checks++; if (short_err !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b expected 0", short_err); end
    endtask

    task automatic test_basic16;
        int base;
        int sbase;
        base  = stb_count;
        sbase = short_count;
        send_frame(32'hA55A, 32'h1234, 16);
        n_checks++; if (stb_count - base !== 0) begin n_fail++; $display("FAIL b16_sync_frame_stb: got %0d expected 0", stb_count - base); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL b16_sync_frame_locked: got %b expected 0", locked); end
        send_frame(32'hA55A, 32'h1234, 16);
        n_checks++; if (stb_count - base !== 1) begin n_fail++; $display("FAIL b16_first_stb: got %0d expected 1", stb_count - base); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL b16_locked: got %b expected 1", locked); end
        n_checks++; if (left_chan !== 16'hA55A) begin n_fail++; $display("FAIL b16_left: got %h expected a55a", left_chan); end
        n_checks++; if (right_chan !== 16'h1234) begin n_fail++; $display("FAIL b16_right: got %h expected 1234", right_chan); end
        send_frame(32'hA55A, 32'h1234, 16);
        n_checks++; if (stb_count - base !== 2) begin n_fail++; $display("FAIL b16_second_stb: got %0d expected 2", stb_count - base); end
        n_checks++; if (short_count - sbase !== 0) begin n_fail++; $display("FAIL b16_short: got %0d expected 0", short_count - sbase); end
    endtask

    task automatic test_long24;
        int base;
        int sbase;
        base  = stb_count;
        sbase = short_count;
        send_frame(32'hABCDEF, 32'h123456, 24);
        send_frame(32'hABCDEF, 32'h123456, 24);
        n_checks++; if (stb_count - base !== 2) begin n_fail++; $display("FAIL l24_stb: got %0d expected 2", stb_count - base); end
        n_checks++; if (left_chan !== 16'hABCD) begin n_fail++; $display("FAIL l24_left: got %h expected abcd", left_chan); end
        n_checks++; if (right_chan !== 16'h1234) begin n_fail++; $display("FAIL l24_right: got %h expected 1234", right_chan); end
        n_checks++; if (short_count - sbase !== 0) begin n_fail++; $display("FAIL l24_short: got %0d expected 0", short_count - sbase); end
    endtask

    task automatic test_short12;
        int base;
        int sbase;
        base  = stb_count;
        sbase = short_count;
        send_frame(32'hFFF, 32'h001, 12);
        send_frame(32'hFFF, 32'h001, 12);
        n_checks++; if (stb_count - base !== 2) begin n_fail++; $display("FAIL s12_stb: got %0d expected 2", stb_count - base); end
        n_checks++; if (left_chan !== 16'hFFF0) begin n_fail++; $display("FAIL s12_left: got %h expected fff0", left_chan); end
        n_checks++; if (right_chan !== 16'h0010) begin n_fail++; $display("FAIL s12_right: got %h expected 0010", right_chan); end
        n_checks++; if (short_count - sbase !== 4) begin n_fail++; $display("FAIL s12_short: got %0d expected 4", short_count - sbase); end
    endtask

    task automatic test_reset_mid_right;
        int base;
        reset_n = 1'b0;
        send_bits(1'b1, 32'h5A5A, 15, 8);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmr_locked_in_reset: got %b expected 0", locked); end
        reset_n = 1'b1;
        base = stb_count;
        send_bits(1'b1, 32'h5A5A, 7, 0);
        n_checks++; if (stb_count - base !== 0) begin n_fail++; $display("FAIL rmr_partial_stb: got %0d expected 0", stb_count - base); end
        send_bits(1'b0, 32'h1111, 15, 0);
        n_checks++; if (stb_count - base !== 0) begin n_fail++; $display("FAIL rmr_left_only_stb: got %0d expected 0", stb_count - base); end
        send_bits(1'b1, 32'h2222, 15, 0);
        n_checks++; if (stb_count - base !== 1) begin n_fail++; $display("FAIL rmr_stb: got %0d expected 1", stb_count - base); end
        n_checks++; if (left_chan !== 16'h1111) begin n_fail++; $display("FAIL rmr_left: got %h expected 1111", left_chan); end
        n_checks++; if (right_chan !== 16'h2222) begin n_fail++; $display("FAIL rmr_right: got %h expected 2222", right_chan); end
    endtask

    task automatic test_timeout;
        int base;
        base = stb_count;
        send_bits(1'b0, 32'h3333, 15, 8);
        repeat (100) @(negedge clk);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL to_locked_before: got %b expected 1", locked); end
        repeat (TIMEOUT + 4) @(negedge clk);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL to_locked_after: got %b expected 0", locked); end
        n_checks++; if (left_chan !== 16'h1111) begin n_fail++; $display("FAIL to_left_hold: got %h expected 1111", left_chan); end
        n_checks++; if (right_chan !== 16'h2222) begin n_fail++; $display("FAIL to_right_hold: got %h expected 2222", right_chan); end
        send_bits(1'b0, 32'h3333, 7, 0);
        send_bits(1'b1, 32'h4444, 15, 0);
        n_checks++; if (stb_count - base !== 0) begin n_fail++; $display("FAIL to_resync_stb: got %0d expected 0", stb_count - base); end
        send_frame(32'h5555, 32'h6666, 16);
        n_checks++; if (stb_count - base !== 1) begin n_fail++; $display("FAIL to_after_stb: got %0d expected 1", stb_count - base); end
        n_checks++; if (left_chan !== 16'h5555) begin n_fail++; $display("FAIL to_left: got %h expected 5555", left_chan); end
        n_checks++; if (right_chan !== 16'h6666) begin n_fail++; $display("FAIL to_right: got %h expected 6666", right_chan); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL to_relocked: got %b expected 1", locked); end
    endtask

    task automatic test_reset_pulse;
        int base;
        base = stb_count;
        send_bits(1'b0, 32'h7777, 15, 8);
        reset_n = 1'b0;
        #2;
        n_checks++; if (left_chan !== 16'h0) begin n_fail++; $display("FAIL rp_left: got %h expected 0000", left_chan); end
        n_checks++; if (right_chan !== 16'h0) begin n_fail++; $display("FAIL rp_right: got %h expected 0000", right_chan); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rp_locked: got %b expected 0", locked); end
        #8;
        reset_n = 1'b1;
        send_bits(1'b0, 32'h7777, 7, 0);
        send_bits(1'b1, 32'h8888, 15, 0);
        n_checks++; if (stb_count - base !== 0) begin n_fail++; $display("FAIL rp_frame_stb: got %0d expected 0", stb_count - base); end
        send_frame(32'h9999, 32'hAAAA, 16);
        n_checks++; if (stb_count - base !== 1) begin n_fail++; $display("FAIL rp_next_stb: got %0d expected 1", stb_count - base); end
        n_checks++; if (left_chan !== 16'h9999) begin n_fail++; $display("FAIL rp_next_left: got %h expected 9999", left_chan); end
        n_checks++; if (right_chan !== 16'hAAAA) begin n_fail++; $display("FAIL rp_next_right: got %h expected aaaa", right_chan); end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_basic16();
        test_long24();
        test_short12();
        test_reset_mid_right();
        test_timeout();
        test_reset_pulse();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
